// File: rtl/mac_relay_pkg.sv
// Shared types and constants for the MAC frame relay.
package mac_relay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD,
        SEND
    } state_e;

    localparam logic [1:0] MOD_FULL = 2'd0;
    localparam logic [5:0] ERR_NONE = 6'd0;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic [31:0] data;
    } tx_word_t;

endpackage

// File: rtl/mac_relay_dpram.sv
// Simple dual-port frame buffer: one write port, one registered read port, same clock.
module mac_relay_dpram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int W     = 34
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset so this maps onto block RAM;
    // consumers qualify rdata_o with their own valid flag.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mac_frame_relay.sv
// Store-and-forward relay: buffers one MAC RX frame, drops errored or oversize frames,
// and replays good frames onto a MAC TX FIFO interface under ff_tx_rdy backpressure.
module mac_frame_relay
    import mac_relay_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int CNT_W = 16
) (
    input  logic             Clk_user,
    input  logic             Reset_n,
    input  logic [31:0]      ff_rx_data,
    input  logic [1:0]       ff_rx_mod,
    input  logic             ff_rx_sop,
    input  logic             ff_rx_eop,
    input  logic             ff_rx_dval,
    input  logic [5:0]       rx_err,
    output logic             ff_rx_rdy,
    output logic [31:0]      ff_tx_data,
    output logic [1:0]       ff_tx_mod,
    output logic             ff_tx_sop,
    output logic             ff_tx_eop,
    output logic             ff_tx_wren,
    output logic             ff_tx_err,
    input  logic             ff_tx_rdy,
    output logic [CNT_W-1:0] fwd_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam logic [AW:0] FULL_PTR = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    state_e           state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    last_ptr_q, last_ptr_d;
    logic             rx_rdy_q;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]   drop_sum;

    logic             rx_acc, rx_bad, we;
    logic [AW-1:0]    waddr;
    logic [1:0]       drop_inc;
    logic             fwd_inc;

    logic [AW:0]      rd_ptr_q;
    logic             a_valid_q, a_sop_q, a_eop_q;
    tx_word_t         tx_q;
    logic             wren_q;
    logic             rd_en, load_b, xfer, tx_done;
    logic [33:0]      ram_rdata;

    assign rx_acc = ff_rx_dval && rx_rdy_q;
    assign rx_bad = (rx_err != ERR_NONE);

    mac_relay_dpram #(.DEPTH(DEPTH), .AW(AW), .W(34)) u_ram (
        .clk     (Clk_user),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i ({(ff_rx_eop ? ff_rx_mod : MOD_FULL), ff_rx_data}),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        last_ptr_d = last_ptr_q;
        we         = 1'b0;
        waddr      = wr_ptr_q[AW-1:0];
        drop_inc   = 2'd0;
        fwd_inc    = 1'b0;
        if (rx_acc && ff_rx_sop) begin
            // A new start abandons any partial frame, then the eop rule sees the new frame.
            if (state_q == RECV) drop_inc = drop_inc + 2'd1;
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = PTR_ONE;
            state_d  = RECV;
            if (ff_rx_eop) begin
                if (rx_bad) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                end else begin
                    last_ptr_d = '0;
                    state_d    = SEND;
                end
            end
        end else if (rx_acc && state_q == RECV) begin
            if (wr_ptr_q == FULL_PTR) begin
                drop_inc = drop_inc + 2'd1;
                state_d  = ff_rx_eop ? IDLE : DISCARD;
            end else if (ff_rx_eop) begin
                if (rx_bad) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                end else begin
                    we         = 1'b1;
                    last_ptr_d = wr_ptr_q[AW-1:0];
                    state_d    = SEND;
                end
            end else begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end else if (rx_acc && state_q == DISCARD && ff_rx_eop) begin
            state_d = IDLE;
        end
        if (tx_done) begin
            fwd_inc = 1'b1;
            state_d = IDLE;
        end

        drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, drop_inc};
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        fwd_cnt_d  = (fwd_inc && fwd_cnt_q != '1) ? fwd_cnt_q + CNT_W'(1) : fwd_cnt_q;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge Clk_user or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            last_ptr_q <= '0;
            rx_rdy_q   <= 1'b0;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            last_ptr_q <= last_ptr_d;
            rx_rdy_q   <= (state_d != SEND);
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Two-stage read pipe: RAM output register (stage A) feeds the TX holding register.
    assign xfer    = wren_q && ff_tx_rdy;
    assign load_b  = a_valid_q && (!wren_q || ff_tx_rdy);
    assign rd_en   = (state_q == SEND) && (rd_ptr_q <= {1'b0, last_ptr_q}) && (!a_valid_q || load_b);
    assign tx_done = xfer && tx_q.eop;

    always_ff @(posedge Clk_user or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr_q  <= '0;
            a_valid_q <= 1'b0;
            a_sop_q   <= 1'b0;
            a_eop_q   <= 1'b0;
            tx_q      <= '0;
            wren_q    <= 1'b0;
        end else if (state_q != SEND) begin
            rd_ptr_q  <= '0;
            a_valid_q <= 1'b0;
            tx_q      <= '0;
            wren_q    <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                a_valid_q <= 1'b1;
                a_sop_q   <= (rd_ptr_q == '0);
                a_eop_q   <= (rd_ptr_q[AW-1:0] == last_ptr_q);
            end else if (load_b) begin
                a_valid_q <= 1'b0;
            end
            if (load_b) begin
                wren_q    <= 1'b1;
                tx_q.sop  <= a_sop_q;
                tx_q.eop  <= a_eop_q;
                tx_q.mod  <= a_eop_q ? ram_rdata[33:32] : MOD_FULL;
                tx_q.data <= ram_rdata[31:0];
            end else if (xfer) begin
                wren_q <= 1'b0;
                tx_q   <= '0;
            end
        end
    end

    assign ff_rx_rdy  = rx_rdy_q;
    assign ff_tx_data = tx_q.data;
    assign ff_tx_mod  = tx_q.mod;
    assign ff_tx_sop  = tx_q.sop;
    assign ff_tx_eop  = tx_q.eop;
    assign ff_tx_wren = wren_q;
    assign ff_tx_err  = 1'b0;
    assign fwd_cnt    = fwd_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mac_frame_relay.sv
// Scoreboard bench for mac_frame_relay: driver pushes expected TX words, monitor pops on transfer.
module tb_mac_frame_relay;

    logic        clk;
    logic        Reset_n;
    logic [31:0] ff_rx_data;
    logic [1:0]  ff_rx_mod;
    logic        ff_rx_sop, ff_rx_eop, ff_rx_dval;
    logic [5:0]  rx_err;
    logic        ff_rx_rdy;
    logic [31:0] ff_tx_data;
    logic [1:0]  ff_tx_mod;
    logic        ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err;
    logic        ff_tx_rdy;
    logic [15:0] fwd_cnt, drop_cnt;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          lat_frames = 0;
    int          lat_checked = 0;
    int          eop_cyc = 0;
    bit          rdy_toggle = 0;
    int          rdy_phase = 0;
    logic [36:0] sb_q[$];

    logic        prev_wren = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [36:0] prev_snap = '0;
    logic [36:0] mon_act, mon_exp;

    mac_frame_relay dut (
        .Clk_user   (clk),
        .Reset_n    (Reset_n),
        .ff_rx_data (ff_rx_data),
        .ff_rx_mod  (ff_rx_mod),
        .ff_rx_sop  (ff_rx_sop),
        .ff_rx_eop  (ff_rx_eop),
        .ff_rx_dval (ff_rx_dval),
        .rx_err     (rx_err),
        .ff_rx_rdy  (ff_rx_rdy),
        .ff_tx_data (ff_tx_data),
        .ff_tx_mod  (ff_tx_mod),
        .ff_tx_sop  (ff_tx_sop),
        .ff_tx_eop  (ff_tx_eop),
        .ff_tx_wren (ff_tx_wren),
        .ff_tx_err  (ff_tx_err),
        .ff_tx_rdy  (ff_tx_rdy),
        .fwd_cnt    (fwd_cnt),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] wdata(input int f, input int i);
        return {8'(f), 8'(i * 37 + 1), 16'(i ^ 16'h5a5a)};
    endfunction

    // TX readiness: always 1, or the repeating 1,0,0,1 pattern.
    initial begin
        ff_tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ff_tx_rdy = rdy_toggle ? ((rdy_phase % 4 == 0) || (rdy_phase % 4 == 3)) : 1'b1;
            rdy_phase++;
        end
    end

    // Monitor: pops and compares on every transfer, checks hold, latency and rx backpressure.
    initial begin
        forever begin
            @(negedge clk);
            mon_act = {ff_tx_err, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_data};
            if (Reset_n && prev_wren && !prev_rdy)
                check("tx_hold_while_not_ready", {27'd0, ff_tx_wren, mon_act}, {27'd0, 1'b1, prev_snap});
            if (ff_tx_wren && !prev_wren && ff_tx_sop && lat_checked < lat_frames) begin
                check("first_wren_latency", 64'(cyc - eop_cyc), 64'd2);
                lat_checked++;
            end
            if (ff_tx_wren)
                check("rx_rdy_low_in_send", {63'd0, ff_rx_rdy}, 64'd0);
            if (ff_tx_wren && ff_tx_rdy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_word: got %h expected no transfer at cycle %0d", mon_act, cyc);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("tx_word", {27'd0, mon_act}, {27'd0, mon_exp});
                end
                xfer_cnt++;
            end
            prev_wren = ff_tx_wren;
            prev_rdy  = ff_tx_rdy;
            prev_snap = mon_act;
        end
    end

    // Entered and left at posedge+1; returns after the word's accept edge.
    task automatic put_word(input logic [31:0] d, input logic sop, input logic eop,
                            input logic [1:0] mod, input logic [5:0] err, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        ff_rx_data = d;
        ff_rx_sop  = sop;
        ff_rx_eop  = eop;
        ff_rx_mod  = mod;
        rx_err     = err;
        ff_rx_dval = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (ff_rx_rdy) ok = 1'b1;
            n++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_accept_timeout: got ff_rx_rdy=0 for %0d cycles expected 1", n);
        end
        ff_rx_dval = 1'b0;
        ff_rx_sop  = 1'b0;
        ff_rx_eop  = 1'b0;
        ff_rx_mod  = 2'd0;
        rx_err     = 6'd0;
    endtask

    task automatic send_frame(input int fid, input int nw, input logic [1:0] last_mod,
                              input logic [5:0] err, input bit fwd);
        logic [31:0] d;
        logic        sop, eop;
        logic [1:0]  mod;
        bit          ok;
        for (int i = 0; i < nw; i++) begin
            d   = wdata(fid, i);
            sop = (i == 0);
            eop = (i == nw - 1);
            mod = eop ? last_mod : 2'd0;
            put_word(d, sop, eop, mod, eop ? err : 6'd0, ok);
            if (ok && fwd) sb_q.push_back({1'b0, sop, eop, mod, d});
            if (ok && fwd && eop) begin
                eop_cyc = cyc;
                lat_frames++;
            end
            if (nw > 512 && (i == 511 || i == 512))
                check("oversize_drop_point", 64'(drop_cnt), (i == 512) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d words pending busy=%0b expected 0 pending", sb_q.size(), busy);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input int fwd, input int drop);
        check({name, "_fwd_cnt"}, 64'(fwd_cnt), 64'(fwd));
        check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(drop));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        sb_q.delete();
        check("reset_ctrl_outputs",
              {57'd0, ff_rx_rdy, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, busy}, 64'd0);
        check("reset_tx_data", 64'(ff_tx_data), 64'd0);
        check("reset_counters", {32'd0, fwd_cnt, drop_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rx_rdy_after_reset", {63'd0, ff_rx_rdy}, 64'd1);
    endtask

    initial begin
        int x0;
        int n;
        Reset_n    = 1'b0;
        ff_rx_data = '0;
        ff_rx_mod  = '0;
        ff_rx_sop  = 1'b0;
        ff_rx_eop  = 1'b0;
        ff_rx_dval = 1'b0;
        rx_err     = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 64-byte frame, straight through
        send_frame(1, 16, 2'd0, 6'd0, 1'b1);
        wait_idle();
        check_counts("f64", 1, 0);

        // 65-byte frame, one valid byte in the last word
        do_reset();
        send_frame(2, 17, 2'd3, 6'd0, 1'b1);
        wait_idle();
        check_counts("f65", 1, 0);

        // errored frame is dropped, the next one forwards
        do_reset();
        send_frame(3, 16, 2'd0, 6'h02, 1'b0);
        check("err_frame_drop", 64'(drop_cnt), 64'd1);
        send_frame(4, 16, 2'd0, 6'd0, 1'b1);
        wait_idle();
        check_counts("err_then_good", 1, 1);

        // oversize frame is discarded, the next one forwards
        do_reset();
        send_frame(5, 600, 2'd0, 6'd0, 1'b0);
        send_frame(6, 16, 2'd0, 6'd0, 1'b1);
        wait_idle();
        check_counts("oversize", 1, 1);

        // backpressure with ff_tx_rdy pattern 1,0,0,1
        do_reset();
        x0 = xfer_cnt;
        rdy_toggle = 1'b1;
        send_frame(7, 17, 2'd3, 6'd0, 1'b1);
        wait_idle();
        rdy_toggle = 1'b0;
        check("backpressure_xfers", 64'(xfer_cnt - x0), 64'd17);
        check_counts("backpressure", 1, 0);

        // reset after five words have gone out
        do_reset();
        x0 = xfer_cnt;
        send_frame(8, 16, 2'd0, 6'd0, 1'b1);
        n = 0;
        while (xfer_cnt < x0 + 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL midsend_wait_timeout: got %0d transfers expected 5", xfer_cnt - x0);
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("no_wren_after_midsend_reset", {63'd0, ff_tx_wren}, 64'd0);
        send_frame(9, 16, 2'd0, 6'd0, 1'b1);
        wait_idle();
        check_counts("after_midsend_reset", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
